// File: rtl/rhd_spi_slave.sv
// rhd_spi_slave: SPI slave for RHD-style command/response framing.
// Commands arrive MSB first on MOSI. Responses run through a two-deep pipeline,
// so the response to command N is shifted out during valid frame N+2.
// SCLK, CS and MOSI are asynchronous to clk and are resynchronised first.
module rhd_spi_slave #(
   parameter int WORD_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              SCLK,
   input  logic              CS,
   input  logic              MOSI,
   output logic              MISO,
   output logic [WORD_W-1:0] rx_word,
   output logic              rx_valid,
   input  logic [WORD_W-1:0] resp_word,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(WORD_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   // synchronizer chains and edge-detect history
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_fill;
   logic                   r_sclk_d;
   logic                   r_cs_d;
   logic                   r_armed;

   logic w_sclk;
   logic w_cs;
   logic w_mosi;
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_fall;
   logic w_cs_rise;

   // frame state
   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [WORD_W-1:0] r_rx_shift;
   logic [WORD_W-1:0] r_tx_shift;
   logic [WORD_W-1:0] r_pipe_q0;
   logic [WORD_W-1:0] r_pipe_q1;
   logic [WORD_W-1:0] r_rx_word;
   logic              r_rx_valid;
   logic              r_frame_err;
   logic              r_miso;
   logic [WORD_W-1:0] w_tx_load;

   // Shift the asynchronous inputs through the synchronizer chains.
   // r_fill tracks which stages hold real post-reset samples rather than reset values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_fill      <= '0;
      end else begin
         r_sclk_sync[0] <= SCLK;
         r_cs_sync[0]   <= CS;
         r_mosi_sync[0] <= MOSI;
         r_fill[0]      <= 1'b1;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            r_sclk_sync[i] <= r_sclk_sync[i-1];
            r_cs_sync[i]   <= r_cs_sync[i-1];
            r_mosi_sync[i] <= r_mosi_sync[i-1];
            r_fill[i]      <= r_fill[i-1];
         end
      end
   end

   assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs   = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   // History flops for edge detection; r_armed only sets once a genuine CS-high
   // sample has been seen, so a CS already low at reset release cannot start a frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sclk_d <= 1'b0;
         r_cs_d   <= 1'b1;
         r_armed  <= 1'b0;
      end else begin
         r_sclk_d <= w_sclk;
         r_cs_d   <= w_cs;
         r_armed  <= r_armed | (r_fill[SYNC_STAGES-1] & w_cs);
      end
   end

   assign w_sclk_rise = w_sclk & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk & r_sclk_d;
   assign w_cs_fall   = r_armed & r_cs_d & ~w_cs;
   assign w_cs_rise   = w_cs & ~r_cs_d;

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: CS edges drive the frame; FINISH always lasts one clk.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_cs_fall) w_state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (w_cs_rise) w_state_nxt = ST_FINISH;
         ST_FINISH: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // The response pipeline advances in the rx_valid cycle. A frame starting in that
   // same cycle must see the value pipe_q1 is about to take, so forward pipe_q0.
   assign w_tx_load = r_rx_valid ? r_pipe_q0 : r_pipe_q1;

   // Frame datapath: shift registers, bit counter, MISO, result pulses and pipeline.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_bit_cnt   <= '0;
         r_rx_shift  <= '0;
         r_tx_shift  <= '0;
         r_pipe_q0   <= '0;
         r_pipe_q1   <= '0;
         r_rx_word   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_miso      <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;

         if (r_rx_valid) begin
            r_pipe_q1 <= r_pipe_q0;
            r_pipe_q0 <= resp_word;
         end

         case (r_state)
            ST_IDLE: begin
               r_miso <= 1'b0;
               if (w_cs_fall) begin
                  r_bit_cnt  <= '0;
                  r_rx_shift <= '0;
                  r_tx_shift <= w_tx_load;
                  r_miso     <= w_tx_load[WORD_W-1];
               end
            end
            ST_ACTIVE: begin
               if (w_cs_rise) begin
                  r_miso <= 1'b0;
               end else if (w_sclk_rise) begin
                  r_rx_shift <= {r_rx_shift[WORD_W-2:0], w_mosi};
                  if (r_bit_cnt != CNT_SAT) begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else if (w_sclk_fall) begin
                  // zero fill means MISO reads 0 once the whole word has gone out
                  r_tx_shift <= {r_tx_shift[WORD_W-2:0], 1'b0};
                  r_miso     <= r_tx_shift[WORD_W-2];
               end
            end
            ST_FINISH: begin
               r_miso <= 1'b0;
               if (r_bit_cnt == CNT_FULL) begin
                  r_rx_word  <= r_rx_shift;
                  r_rx_valid <= 1'b1;
               end else begin
                  r_frame_err <= 1'b1;
               end
            end
            default: begin
               r_miso <= 1'b0;
            end
         endcase
      end
   end

   assign MISO      = r_miso;
   assign rx_word   = r_rx_word;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign busy      = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_rhd_spi_slave.sv
// Directed bench for rhd_spi_slave: a bench-side SPI master plus a frame-level
// model (response history list, last good command) checked every clk.
module tb_rhd_spi_slave;

   logic        clk = 1'b0;
   logic        rstn;
   logic        SCLK;
   logic        CS;
   logic        MOSI;
   logic        MISO;
   logic [31:0] rx_word;
   logic        rx_valid;
   logic [31:0] resp_word;
   logic        frame_err;
   logic        busy;

   rhd_spi_slave #(.WORD_W(32), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .SCLK      (SCLK),
      .CS        (CS),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .rx_word   (rx_word),
      .rx_valid  (rx_valid),
      .resp_word (resp_word),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_valid_seen = 0;
   int n_err_seen   = 0;
   int m_exp_valid  = 0;
   int m_exp_err    = 0;
   bit chk_en = 1'b0;
   bit mode   = 1'b0;
   int half   = 4;
   int skew   = 0;

   logic [31:0] m_rx_word  = '0;
   logic [31:0] m_pending  = '0;
   logic [31:0] hist[$];
   logic [31:0] rd;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] resp_fn(input logic [31:0] c);
      return mode ? c + 32'd1 : ~c;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #(2 + skew);
   endtask

   task automatic check_counts(input string nm);
      chk({nm, "_valid_cnt"}, n_valid_seen, m_exp_valid);
      chk({nm, "_err_cnt"}, n_err_seen, m_exp_err);
   endtask

   // Idle-time reset: clears the DUT and the model's pipeline history.
   task automatic do_reset();
      hist.delete();
      m_rx_word = '0;
      rstn = 1'b0;
      tick(2);
      rstn = 1'b1;
      tick(4);
   endtask

   // Reset in the middle of a frame, then release with CS still low.
   task automatic reset_mid();
      hist.delete();
      m_rx_word = '0;
      rstn = 1'b0;
      #1;
      chk("rst_mid_miso", MISO, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rx_word", rx_word, 0);
      chk("rst_mid_rx_valid", rx_valid, 0);
      chk("rst_mid_frame_err", frame_err, 0);
      tick(3);
      SCLK = 1'b0;
      rstn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick(4);
         SCLK = ~SCLK;
      end
      tick(10);
      chk("rst_cs_low_busy", busy, 0);
      check_counts("rst_cs_low");
      CS = 1'b1;
      tick(10);
   endtask

   // One master transaction: nbits SCLK pulses, MISO sampled before each rising edge.
   task automatic frame(input logic [31:0] cmd, input int nbits, input int gap,
                        input bit do_rst, output logic [31:0] rdw);
      logic [31:0] exp_rd;
      int nv;
      nv = hist.size();
      exp_rd = (nv >= 2) ? hist[nv-2] : 32'd0;
      rdw = '0;
      CS = 1'b0;
      tick(8);
      for (int b = 0; b < nbits; b++) begin
         MOSI = (b < 32) ? cmd[31-b] : 1'b1;
         tick(half);
         rdw = {rdw[30:0], MISO};
         SCLK = 1'b1;
         if (do_rst && b == 10) begin
            reset_mid();
            return;
         end
         tick(half);
         SCLK = 1'b0;
      end
      tick(half);
      if (nbits >= 32) chk("miso_tail", MISO, 0);
      if (nbits == 32) begin
         m_pending = cmd;
         resp_word = resp_fn(cmd);
      end else begin
         resp_word = $urandom;
      end
      CS = 1'b1;
      if (nbits == 32) begin
         chk("miso_read", rdw, exp_rd);
         hist.push_back(resp_fn(cmd));
         m_exp_valid++;
      end else begin
         m_exp_err++;
      end
      tick(gap);
      if (gap >= 10) check_counts("frame");
   endtask

   // Per-clk comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid_err_excl", {31'd0, rx_valid & frame_err}, 0);
         if (!busy) chk("miso_idle", MISO, 0);
         if (rx_valid) begin
            n_valid_seen++;
            chk("rx_word_new", rx_word, m_pending);
            m_rx_word = m_pending;
         end else begin
            chk("rx_word_hold", rx_word, m_rx_word);
         end
         if (frame_err) n_err_seen++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      CS = 1'b1;
      SCLK = 1'b0;
      MOSI = 1'b0;
      resp_word = '0;
      tick(3);
      chk_en = 1'b1;
      chk("reset_rx_word", rx_word, 0);
      chk("reset_miso", MISO, 0);
      chk("reset_busy", busy, 0);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_frame_err", frame_err, 0);
      rstn = 1'b1;
      tick(6);

      // single frame
      frame(32'h80FF_0000, 32, 12, 1'b0, rd);
      chk("single_read", rd, 32'h0000_0000);
      chk("single_rx_word", rx_word, 32'h80FF_0000);

      // three-frame pipeline latency
      do_reset();
      mode = 1'b0;
      frame(32'h1111_1111, 32, 12, 1'b0, rd);
      chk("pipe_read_a", rd, 32'h0);
      frame(32'h2222_2222, 32, 12, 1'b0, rd);
      chk("pipe_read_b", rd, 32'h0);
      frame(32'h3333_3333, 32, 12, 1'b0, rd);
      chk("pipe_read_c", rd, 32'hEEEE_EEEE);

      // abort after 17 rising edges; pipeline must be untouched
      frame(32'hABCD_EF01, 17, 12, 1'b0, rd);
      frame(32'h1234_5678, 32, 12, 1'b0, rd);
      chk("post_abort_read", rd, 32'hDDDD_DDDD);

      // 33 rising edges: saturating count gives frame_err, rx_word held
      frame(32'hFFFF_0000, 33, 12, 1'b0, rd);
      chk("overrun_rx_word", rx_word, 32'h1234_5678);

      // back-to-back frames with CS high only two clks
      frame(32'hC0DE_0001, 32, 2, 1'b0, rd);
      frame(32'hC0DE_0002, 32, 12, 1'b0, rd);

      // reset at bit 10, CS held low through release, then a full frame
      frame(32'h5A5A_A5A5, 32, 12, 1'b1, rd);
      frame(32'h0F0F_F0F0, 32, 12, 1'b0, rd);
      chk("post_reset_read", rd, 32'h0);
      chk("post_reset_rx_word", rx_word, 32'h0F0F_F0F0);

      // loopback with resp = cmd + 1 and swept timing offsets
      do_reset();
      mode = 1'b1;
      for (int i = 0; i < 30; i++) begin
         skew = i % 8;
         half = 4 + (i % 3);
         frame($urandom, 32, 12, 1'b0, rd);
      end
      skew = 0;
      half = 4;
      tick(10);
      check_counts("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rhd_spi_slave.md
RHD_SPI_SLAVE -- requirements
Module: rhd_spi_slave

Interface
REQ-001 SHALL have parameter WORD_W, default 32: bits per SPI frame, MSB first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on SCLK, CS and MOSI.
REQ-003 SHALL have port clk, input, 1: system clock, at least 8x SCLK; the only clock in the block.
REQ-004 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port SCLK, input, 1: SPI clock from the master, asynchronous to clk.
REQ-006 SHALL have port CS, input, 1: active-low chip select from the master.
REQ-007 SHALL have port MOSI, input, 1: serial command data from the master.
REQ-008 SHALL have port MISO, output, 1: serial response data to the master.
REQ-009 SHALL have port rx_word, output, WORD_W: last complete command received.
REQ-010 SHALL have port rx_valid, output, 1: one-clk pulse when rx_word updates.
REQ-011 SHALL have port resp_word, input, WORD_W: response for the command on rx_word; sampled only in the rx_valid cycle.
REQ-012 SHALL have port frame_err, output, 1: one-clk pulse when a frame ends with a bit count other than WORD_W.
REQ-013 SHALL have port busy, output, 1: high while the FSM is in ACTIVE.

Function
REQ-014 SHALL pass SCLK, CS and MOSI through SYNC_STAGES flops, plus one history flop each on SCLK and CS for edge detection; all logic uses only the synchronized copies.
REQ-015 SHALL implement FSM states IDLE, ACTIVE and FINISH.
REQ-016 IDLE -> ACTIVE on a synchronized CS falling edge: clear bit_cnt; load tx_shift from pipe_q1; drive MISO = pipe_q1[WORD_W-1] in the next clk.
REQ-017 In ACTIVE, on each synchronized SCLK rising edge: shift MOSI into rx_shift LSB; increment bit_cnt, saturating at WORD_W+1.
REQ-018 In ACTIVE, on each synchronized SCLK falling edge: shift tx_shift left by one; MISO = new MSB; after WORD_W shifts, MISO = 0.
REQ-019 ACTIVE -> FINISH on a synchronized CS rising edge, including mid-frame abort; FINISH -> IDLE unconditionally after one clk.
REQ-020 In FINISH, if bit_cnt == WORD_W: rx_word <= rx_shift; pulse rx_valid in that same clk; pipe_q1 <= pipe_q0; pipe_q0 <= resp_word.
REQ-021 In FINISH, if bit_cnt != WORD_W: pulse frame_err; leave rx_word, rx_valid and pipe_q0/pipe_q1 unchanged.
REQ-022 Response latency: the response to command N is shifted out during valid frame N+2, matching the RHD two-command pipeline.
REQ-023 MISO SHALL be 0 whenever the FSM is in IDLE or FINISH.
REQ-024 A CS falling edge and an SCLK edge in the same clk: the CS edge takes priority, and that SCLK edge is ignored.
REQ-025 SCLK edges while in IDLE or FINISH SHALL be ignored.
REQ-026 rx_valid and frame_err SHALL never be high in the same clk.
REQ-027 bit_cnt SHALL NOT wrap: more than WORD_W rising edges leave it at WORD_W+1, which yields frame_err.

Reset
REQ-028 While rstn is low, the following SHALL be cleared asynchronously: state = IDLE, MISO = 0, rx_word = 0, rx_valid = 0, frame_err = 0, busy = 0, bit_cnt = 0, all shift registers and pipe_q0/pipe_q1 = 0, synchronizers = idle (CS = 1, SCLK = 0).
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no rx_valid or frame_err; after release, the block waits in IDLE for a new CS falling edge.
REQ-030 Reset release SHALL take effect on the first clk edge after rstn rises; a CS that is already low at release SHALL NOT start a frame until CS goes high and then falls again.

Verification
REQ-031 Single frame (master SCLK = clk/8), MOSI = 0x80FF_0000 -> rx_valid pulses once, rx_word = 0x80FF_0000, MISO shifts out 0x0000_0000.
REQ-032 Three frames A = 0x1111_1111, B = 0x2222_2222, C = 0x3333_3333, with resp_word = ~rx_word in each rx_valid cycle -> the master reads 0, 0, 0xEEEE_EEEE.
REQ-033 CS raised after 17 SCLK rising edges -> frame_err pulses once, no rx_valid, and the next valid frame's MISO equals the pre-abort pipe_q1.
REQ-034 33 SCLK rising edges in one CS window -> frame_err pulses, and rx_word is unchanged.
REQ-035 rstn pulsed low at bit 10 of a frame -> all outputs 0 immediately; CS held low through release produces no activity; a following full frame is received correctly.
REQ-036 Loopback against the existing SPI master (oversample_offset swept 0..7) with resp_word = rx_word + 1 over 1000 random frames -> every data_out equals command[n-2] + 1, with zero frame_err.
